// File: rtl/adt7310_pkg.sv
// Shared definitions for the ADT7310 SPI responder: register map, reset values,
// command-byte fields and FSM encoding.
package adt7310_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CONFIG = 3'd1;
  localparam logic [2:0] ADDR_TEMP   = 3'd2;
  localparam logic [2:0] ADDR_ID     = 3'd3;
  localparam logic [2:0] ADDR_TCRIT  = 3'd4;
  localparam logic [2:0] ADDR_THYST  = 3'd5;
  localparam logic [2:0] ADDR_THIGH  = 3'd6;
  localparam logic [2:0] ADDR_TLOW   = 3'd7;

  // Bit n set: register n is 16 bits wide / register n accepts writes.
  localparam logic [7:0] REG_WIDE     = 8'b1101_0100;
  localparam logic [7:0] REG_WRITABLE = 8'b1111_0010;

  localparam logic [7:0]  STATUS_RST = 8'h80;
  localparam logic [7:0]  CONFIG_RST = 8'h00;
  localparam logic [15:0] TCRIT_RST  = 16'h4980;
  localparam logic [7:0]  THYST_RST  = 8'h05;
  localparam logic [15:0] THIGH_RST  = 16'h2000;
  localparam logic [15:0] TLOW_RST   = 16'h0500;

  // Positions within the command byte (bits 1:0 carry no meaning).
  localparam int CMD_BIT_ZERO = 7;
  localparam int CMD_BIT_READ = 6;
  localparam int CMD_ADDR_MSB = 5;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_BIT_CONT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  function automatic logic [4:0] last_bit(input logic [2:0] addr);
    return REG_WIDE[addr] ? 5'd15 : 5'd7;
  endfunction

endpackage

// File: rtl/adt_spi_sync.sv
// Two-flop synchronizers for the SPI pins plus registered edge pulses; the
// level outputs are delayed to line up with the pulses.
module adt_spi_sync (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic spi_cs,
  input  logic spi_clk,
  input  logic spi_sdi,
  output logic cs_n_s,
  output logic sdi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  // Vector order {sdi, clk, cs}; CS and SCLK reset to their idle-high level.
  localparam logic [2:0] IDLE_LVL = 3'b011;

  logic [2:0] pin_in;
  logic [2:0] meta_reg;
  logic [2:0] sync_reg;
  logic [2:0] dly_reg;
  logic       sclk_rise_reg;
  logic       sclk_fall_reg;
  logic       cs_fall_reg;
  logic       cs_rise_reg;

  assign pin_in = {spi_sdi, spi_clk, spi_cs};

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      meta_reg      <= IDLE_LVL;
      sync_reg      <= IDLE_LVL;
      dly_reg       <= IDLE_LVL;
      sclk_rise_reg <= 1'b0;
      sclk_fall_reg <= 1'b0;
      cs_fall_reg   <= 1'b0;
      cs_rise_reg   <= 1'b0;
    end else begin
      meta_reg      <= pin_in;
      sync_reg      <= meta_reg;
      dly_reg       <= sync_reg;
      sclk_rise_reg <= sync_reg[1] & ~dly_reg[1];
      sclk_fall_reg <= ~sync_reg[1] & dly_reg[1];
      cs_fall_reg   <= ~sync_reg[0] & dly_reg[0];
      cs_rise_reg   <= sync_reg[0] & ~dly_reg[0];
    end
  end

  assign cs_n_s    = dly_reg[0];
  assign sdi_s     = dly_reg[2];
  assign sclk_rise = sclk_rise_reg;
  assign sclk_fall = sclk_fall_reg;
  assign cs_fall   = cs_fall_reg;
  assign cs_rise   = cs_rise_reg;

endmodule

// File: rtl/adt7310_spi_resp.sv
// ADT7310-compatible SPI slave (mode 3, MSB first) backed by a local register
// file and a live temperature input.
module adt7310_spi_resp
  import adt7310_pkg::*;
#(
  parameter logic [7:0] ID_VAL   = 8'hC3,
  parameter logic [5:0] RST_ONES = 6'd32
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] temp_value,
  input  logic        temp_upd,
  output logic [7:0]  cfg_value,
  output logic        reg_wr,
  output logic [2:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        frame_err,
  output logic        if_rst
);

  logic cs_n_s, sdi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  adt_spi_sync u_sync (
    .clk_sys   (clk_sys),
    .rst_sys   (rst_sys),
    .spi_cs    (spi_cs),
    .spi_clk   (spi_clk),
    .spi_sdi   (spi_sdi),
    .cs_n_s    (cs_n_s),
    .sdi_s     (sdi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  state_t      state_reg, state_next;
  logic [4:0]  bit_cnt_reg;
  logic [14:0] sh_reg;
  logic [5:0]  ones_cnt_reg;
  logic [2:0]  cmd_addr_reg;
  logic        cmd_cont_reg;
  logic        cont_boundary_reg;
  logic [15:0] rd_shift_reg;
  logic        rdy_n_reg;
  logic [7:0]  cfg_reg;
  logic [15:0] tcrit_reg;
  logic [7:0]  thyst_reg;
  logic [15:0] thigh_reg;
  logic [15:0] tlow_reg;

  logic        sclk_rise_v, sclk_fall_v, ones_hit;
  logic        cmd_done, rd_last, wr_last, frame_cond;
  logic [7:2]  cmd_field;
  logic [2:0]  cmd_addr;
  logic [15:0] rd_word;
  logic [15:0] wr_word;

  assign sclk_rise_v = sclk_rise & ~cs_n_s;
  assign sclk_fall_v = sclk_fall & ~cs_n_s;
  assign ones_hit    = sclk_rise_v && sdi_s && (ones_cnt_reg == RST_ONES - 6'd1);

  // The command byte completes with the bit arriving on this edge.
  assign cmd_field = sh_reg[6:1];
  assign cmd_addr  = cmd_field[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign wr_word   = REG_WIDE[cmd_addr_reg] ? {sh_reg, sdi_s} : {8'h00, sh_reg[6:0], sdi_s};
  assign cfg_value = cfg_reg;

  // 8-bit registers are left-aligned so the shifter always emits bit 15 first.
  always_comb begin
    rd_word = 16'h0000;
    case (cmd_addr)
      ADDR_STATUS: rd_word = {rdy_n_reg, 7'b0, 8'h00};
      ADDR_CONFIG: rd_word = {cfg_reg, 8'h00};
      ADDR_TEMP:   rd_word = temp_value;
      ADDR_ID:     rd_word = {ID_VAL, 8'h00};
      ADDR_TCRIT:  rd_word = tcrit_reg;
      ADDR_THYST:  rd_word = {thyst_reg, 8'h00};
      ADDR_THIGH:  rd_word = thigh_reg;
      ADDR_TLOW:   rd_word = tlow_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cmd_done   = 1'b0;
    rd_last    = 1'b0;
    wr_last    = 1'b0;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else if (ones_hit) begin
      state_next = ST_IGNORE;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (cs_fall) state_next = ST_CMD;
        ST_CMD: begin
          if (sclk_rise_v && bit_cnt_reg == 5'd7) begin
            cmd_done = 1'b1;
            if (cmd_field[CMD_BIT_ZERO])      state_next = ST_IGNORE;
            else if (cmd_field[CMD_BIT_READ]) state_next = ST_RDATA;
            else                              state_next = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (sclk_rise_v && bit_cnt_reg == last_bit(cmd_addr_reg)) begin
            rd_last = 1'b1;
            if (!cmd_cont_reg) state_next = ST_IGNORE;
          end
        end
        ST_WDATA: begin
          if (sclk_rise_v && bit_cnt_reg == last_bit(cmd_addr_reg)) begin
            wr_last    = 1'b1;
            state_next = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  // A continuous read stopped on a word boundary is a clean end of frame.
  assign frame_cond = cs_rise && ((state_reg == ST_CMD) || (state_reg == ST_WDATA) ||
                                  ((state_reg == ST_RDATA) && !cont_boundary_reg));

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      bit_cnt_reg       <= 5'd0;
      sh_reg            <= 15'd0;
      ones_cnt_reg      <= 6'd0;
      cmd_addr_reg      <= 3'd0;
      cmd_cont_reg      <= 1'b0;
      cont_boundary_reg <= 1'b0;
      rd_shift_reg      <= 16'h0000;
      rdy_n_reg         <= STATUS_RST[7];
      cfg_reg           <= CONFIG_RST;
      tcrit_reg         <= TCRIT_RST;
      thyst_reg         <= THYST_RST;
      thigh_reg         <= THIGH_RST;
      tlow_reg          <= TLOW_RST;
      spi_sdo           <= 1'b1;
      spi_sdo_oe        <= 1'b0;
      reg_wr            <= 1'b0;
      reg_wr_addr       <= 3'd0;
      reg_wr_data       <= 16'h0000;
      frame_err         <= 1'b0;
      if_rst            <= 1'b0;
    end else begin
      reg_wr     <= 1'b0;
      if_rst     <= 1'b0;
      frame_err  <= frame_cond;
      spi_sdo_oe <= (state_next == ST_RDATA);

      if (cs_n_s) begin
        ones_cnt_reg <= 6'd0;
      end else if (sclk_rise_v) begin
        ones_cnt_reg <= (sdi_s && !ones_hit) ? ones_cnt_reg + 6'd1 : 6'd0;
      end

      if (cs_fall) begin
        bit_cnt_reg       <= 5'd0;
        cont_boundary_reg <= 1'b0;
      end else if (sclk_rise_v) begin
        sh_reg            <= {sh_reg[13:0], sdi_s};
        bit_cnt_reg       <= (cmd_done || rd_last || wr_last) ? 5'd0 : bit_cnt_reg + 5'd1;
        cont_boundary_reg <= rd_last && cmd_cont_reg;
      end

      if (cmd_done) begin
        cmd_addr_reg <= cmd_addr;
        cmd_cont_reg <= cmd_field[CMD_BIT_CONT] && cmd_field[CMD_BIT_READ] && (cmd_addr == ADDR_TEMP);
        rd_shift_reg <= rd_word;
      end else if (rd_last && cmd_cont_reg) begin
        rd_shift_reg <= temp_value;
      end else if (sclk_fall_v && state_reg == ST_RDATA) begin
        rd_shift_reg <= {rd_shift_reg[14:0], 1'b0};
      end

      if (state_next != ST_RDATA) spi_sdo <= 1'b1;
      else if (sclk_fall_v)       spi_sdo <= rd_shift_reg[15];

      // Fresh data wins over a read completing in the same cycle.
      if (temp_upd)                                rdy_n_reg <= 1'b0;
      else if (rd_last && cmd_addr_reg == ADDR_TEMP) rdy_n_reg <= 1'b1;

      if (wr_last && REG_WRITABLE[cmd_addr_reg]) begin
        reg_wr      <= 1'b1;
        reg_wr_addr <= cmd_addr_reg;
        reg_wr_data <= wr_word;
        case (cmd_addr_reg)
          ADDR_CONFIG: cfg_reg   <= wr_word[7:0];
          ADDR_TCRIT:  tcrit_reg <= wr_word;
          ADDR_THYST:  thyst_reg <= wr_word[7:0];
          ADDR_THIGH:  thigh_reg <= wr_word;
          ADDR_TLOW:   tlow_reg  <= wr_word;
          default: ;
        endcase
      end

      if (ones_hit) begin
        if_rst    <= 1'b1;
        rdy_n_reg <= STATUS_RST[7];
        cfg_reg   <= CONFIG_RST;
        tcrit_reg <= TCRIT_RST;
        thyst_reg <= THYST_RST;
        thigh_reg <= THIGH_RST;
        tlow_reg  <= TLOW_RST;
      end
    end
  end

endmodule

// File: tb/tb_adt7310_spi_resp.sv
// Scoreboard bench for adt7310_spi_resp: an SPI master task issues frames and
// queues expected events; monitors on the DUT outputs pop and compare.
module tb_adt7310_spi_resp;

  localparam int HALF = 8;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_clk = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe;
  logic [15:0] temp_value = 16'h0000;
  logic        temp_upd = 1'b0;
  logic [7:0]  cfg_value;
  logic        reg_wr;
  logic [2:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        frame_err, if_rst;

  adt7310_spi_resp #(.ID_VAL(8'hC3), .RST_ONES(6'd32)) dut (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .spi_cs      (spi_cs),
    .spi_clk     (spi_clk),
    .spi_sdi     (spi_sdi),
    .spi_sdo     (spi_sdo),
    .spi_sdo_oe  (spi_sdo_oe),
    .temp_value  (temp_value),
    .temp_upd    (temp_upd),
    .cfg_value   (cfg_value),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .frame_err   (frame_err),
    .if_rst      (if_rst)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum int {K_RD, K_WR, K_FERR, K_IFRST} kind_t;
  typedef struct {
    kind_t       kind;
    int          width;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_ev(input kind_t k, input int w, input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = k; e.width = w; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_pulse(input kind_t k, input string name, input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0 || exp_q[0].kind != k) begin
      errors++;
      $display("FAIL %s: unexpected pulse addr=%0d data=%h, required no pulse", name, a, d);
    end else begin
      e = exp_q.pop_front();
      $display("ok   %s pulse", name);
      if (k == K_WR) begin
        chk("reg_wr_addr", {13'd0, a}, {13'd0, e.addr});
        chk("reg_wr_data", d, e.data);
      end
    end
  endtask

  // Pulse monitor.
  always @(negedge clk_sys) begin
    if (!rst_sys) begin
      if (reg_wr)    sb_pulse(K_WR, "reg_wr", reg_wr_addr, reg_wr_data);
      if (frame_err) sb_pulse(K_FERR, "frame_err", 3'd0, 16'h0000);
      if (if_rst)    sb_pulse(K_IFRST, "if_rst", 3'd0, 16'h0000);
    end
  end

  // DOUT monitor: sample like a mode-3 master on each rising SPI clock.
  logic [15:0] rx_word = 16'h0000;
  int          rx_cnt = 0;
  always @(posedge spi_clk or posedge spi_cs) begin
    exp_t e;
    if (spi_cs) begin
      rx_cnt = 0;
    end else if (spi_sdo_oe) begin
      rx_word = {rx_word[14:0], spi_sdo};
      rx_cnt++;
      if (exp_q.size() > 0 && exp_q[0].kind == K_RD && rx_cnt == exp_q[0].width) begin
        e = exp_q.pop_front();
        if (e.width == 8) chk("rd_data8", {8'h00, rx_word[7:0]}, e.data);
        else              chk("rd_data16", rx_word, e.data);
        rx_cnt = 0;
      end else if (rx_cnt >= 16) begin
        checks++;
        errors++;
        $display("FAIL rd_data: unexpected read word %h, required none", rx_word);
        rx_cnt = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic spi_xfer(input int nbits, input logic [47:0] mosi, input bit hold_cs, output bit oe_seen);
    oe_seen = 1'b0;
    @(negedge clk_sys);
    spi_cs = 1'b0;
    wait_cyc(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_clk = 1'b0;
      spi_sdi = mosi[i];
      wait_cyc(HALF);
      spi_clk = 1'b1;
      wait_cyc(HALF);
      if (spi_sdo_oe) oe_seen = 1'b1;
    end
    if (!hold_cs) begin
      wait_cyc(HALF);
      spi_cs = 1'b1;
      wait_cyc(2 * HALF);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    wait_cyc(5);
    chk("rst_sdo_oe", {15'd0, spi_sdo_oe}, 16'h0000);
    rst_sys = 1'b0;
    wait_cyc(5);
    chk("reset_sdo", {15'd0, spi_sdo}, 16'h0001);
    chk("reset_sdo_oe", {15'd0, spi_sdo_oe}, 16'h0000);
    chk("reset_cfg", {8'h00, cfg_value}, 16'h0000);
    chk("reset_pulses", {13'd0, reg_wr, frame_err, if_rst}, 16'h0000);

    // ID read, then a write to the read-only ID register must be dropped.
    expect_ev(K_RD, 8, 3'd0, 16'h00C3);
    spi_xfer(16, 48'h5800, 1'b0, seen);
    spi_xfer(16, 48'h1855, 1'b0, seen);
    expect_ev(K_RD, 8, 3'd0, 16'h00C3);
    spi_xfer(16, 48'h5800, 1'b0, seen);

    // Tcrit 16-bit write/readback; Thyst 8-bit write/readback.
    expect_ev(K_WR, 0, 3'd4, 16'h4B00);
    spi_xfer(24, 48'h204B00, 1'b0, seen);
    expect_ev(K_RD, 16, 3'd0, 16'h4B00);
    spi_xfer(24, 48'h600000, 1'b0, seen);
    expect_ev(K_WR, 0, 3'd5, 16'h001A);
    spi_xfer(16, 48'h281A, 1'b0, seen);
    expect_ev(K_RD, 8, 3'd0, 16'h001A);
    spi_xfer(16, 48'h6800, 1'b0, seen);

    // New temperature clears RDY_n; a continuous read returns it twice and sets RDY_n.
    temp_value = 16'h0C80;
    @(negedge clk_sys); temp_upd = 1'b1;
    @(negedge clk_sys); temp_upd = 1'b0;
    expect_ev(K_RD, 8, 3'd0, 16'h0000);
    spi_xfer(16, 48'h4000, 1'b0, seen);
    expect_ev(K_RD, 16, 3'd0, 16'h0C80);
    expect_ev(K_RD, 16, 3'd0, 16'h0C80);
    spi_xfer(40, 48'h5400000000, 1'b0, seen);
    expect_ev(K_RD, 8, 3'd0, 16'h0080);
    spi_xfer(16, 48'h4000, 1'b0, seen);

    // Config write aborted after 4 data bits.
    expect_ev(K_FERR, 0, 3'd0, 16'h0000);
    spi_xfer(12, 48'h088, 1'b0, seen);
    chk("abort_cfg", {8'h00, cfg_value}, 16'h0000);

    // Config write, then 32 DIN ones restore every register.
    expect_ev(K_WR, 0, 3'd1, 16'h0080);
    spi_xfer(16, 48'h0880, 1'b0, seen);
    chk("cfg_written", {8'h00, cfg_value}, 16'h0080);
    expect_ev(K_IFRST, 0, 3'd0, 16'h0000);
    spi_xfer(32, 48'hFFFFFFFF, 1'b0, seen);
    chk("ifrst_cfg", {8'h00, cfg_value}, 16'h0000);
    expect_ev(K_RD, 16, 3'd0, 16'h4980);
    spi_xfer(24, 48'h600000, 1'b0, seen);

    // rst_sys in the middle of a Thigh read drops the drive immediately.
    spi_xfer(12, 48'h700, 1'b1, seen);
    chk("thigh_sdo_oe_driving", {15'd0, spi_sdo_oe}, 16'h0001);
    @(negedge clk_sys);
    rst_sys = 1'b1;
    #1;
    chk("midrst_sdo_oe", {15'd0, spi_sdo_oe}, 16'h0000);
    chk("midrst_sdo", {15'd0, spi_sdo}, 16'h0001);
    wait_cyc(3);
    spi_cs = 1'b1;
    wait_cyc(4);
    rst_sys = 1'b0;
    wait_cyc(6);

    // Command with bit7 set is ignored: no drive, no write.
    spi_xfer(16, 48'hC000, 1'b0, seen);
    chk("c0_oe_seen", {15'd0, seen}, 16'h0000);
    expect_ev(K_RD, 8, 3'd0, 16'h00C3);
    spi_xfer(16, 48'h5800, 1'b0, seen);

    wait_cyc(20);
    chk("sb_drain", exp_q.size(), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
